memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 27 ++
 rtl/read_return_pipe.sv | 53 +++++
 rtl/memory_arbiter.sv | 144 ++++++++++++++
 tb/tb_memory_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the ZBT memory arbiter.
// Requester tags, swap states and word geometry.
package memory_arbiter_pkg;

    localparam int OFF_W  = 17;
    localparam int WORD_W = 36;
    localparam int ADDR_W = OFF_W + 1;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_PROC = 2'd2
    } tag_e;

    typedef enum logic {
        CAPTURING = 1'b0,
        PENDING   = 1'b1
    } swap_e;

    function automatic logic [ADDR_W-1:0] mk_addr(
        input logic             buf_bit,
        input logic [OFF_W-1:0] off
    );
        return {buf_bit, off};
    endfunction

endpackage

// File: rtl/read_return_pipe.sv
// Read return routing for the ZBT arbiter.
// Tags follow each access so returning data reaches its requester.
module read_return_pipe
    import memory_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  tag_e              tag_in,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] vga_pixel,
    output logic              done_vga,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              proc_rvalid
);

    tag_e tags [RD_LAT+1];

    // Shift tags alongside the access; last stage lines up with mem_rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tags[i] <= TAG_NONE;
            end
        end else begin
            tags[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Capture returning word for its owner; data holds while valid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_vga    <= 1'b0;
            proc_rvalid <= 1'b0;
            vga_pixel   <= '0;
            proc_rdata  <= '0;
        end else begin
            done_vga    <= (tags[RD_LAT] == TAG_VGA);
            proc_rvalid <= (tags[RD_LAT] == TAG_PROC);
            if (tags[RD_LAT] == TAG_VGA) begin
                vga_pixel <= mem_rdata;
            end
            if (tags[RD_LAT] == TAG_PROC) begin
                proc_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// ZBT arbiter for VGA scan-out, NTSC capture and processing.
// Double-buffered frames; proc is promoted over ntsc when starved.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_flag,
    input  logic              ntsc_frame_done,
    input  logic              vga_flag,
    input  logic [OFF_W-1:0]  vga_addr,
    output logic              vga_grant,
    output logic [WORD_W-1:0] vga_pixel,
    output logic              done_vga,
    input  logic              ntsc_flag,
    input  logic [OFF_W-1:0]  ntsc_addr,
    input  logic [WORD_W-1:0] ntsc_data,
    output logic              ntsc_ack,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [OFF_W-1:0]  proc_addr,
    input  logic [WORD_W-1:0] proc_wdata,
    output logic              proc_ack,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              proc_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              display_buf
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    swap_e            state;
    tag_e             tag_in;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Fixed priority vga > ntsc > proc, proc jumps ntsc once starved.
    always_comb begin
        vga_grant = 1'b0;
        ntsc_ack  = 1'b0;
        proc_ack  = 1'b0;
        tag_in    = TAG_NONE;
        if (!reset) begin
            vga_grant = vga_flag;
            ntsc_ack  = !vga_flag && ntsc_flag && !(proc_req && starved);
            proc_ack  = !vga_flag && proc_req && (!ntsc_flag || starved);
        end
        if (vga_grant) begin
            tag_in = TAG_VGA;
        end else if (proc_ack && !proc_we) begin
            tag_in = TAG_PROC;
        end
    end

    // Count consecutive denied proc cycles, saturating at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (proc_ack || !proc_req) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Register the granted access onto the ZBT port; idle keeps address.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (1'b1)
                vga_grant: begin
                    mem_addr <= mk_addr(display_buf, vga_addr);
                end
                ntsc_ack: begin
                    mem_addr  <= mk_addr(!display_buf, ntsc_addr);
                    mem_we    <= 1'b1;
                    mem_wdata <= ntsc_data;
                end
                proc_ack: begin
                    mem_addr <= mk_addr(!display_buf, proc_addr);
                    mem_we   <= proc_we;
                    if (proc_we) begin
                        mem_wdata <= proc_wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer swap: wait for a captured frame, flip at next frame boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CAPTURING;
            display_buf <= 1'b0;
        end else begin
            unique case (state)
                CAPTURING: begin
                    if (ntsc_frame_done && frame_flag) begin
                        display_buf <= !display_buf;
                    end else if (ntsc_frame_done) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_flag) begin
                        display_buf <= !display_buf;
                        state       <= CAPTURING;
                    end
                end
                default: begin
                    state <= CAPTURING;
                end
            endcase
        end
    end

    read_return_pipe #(
        .RD_LAT(RD_LAT)
    ) u_ret (
        .clock      (clock),
        .reset      (reset),
        .tag_in     (tag_in),
        .mem_rdata  (mem_rdata),
        .vga_pixel  (vga_pixel),
        .done_vga   (done_vga),
        .proc_rdata (proc_rdata),
        .proc_rvalid(proc_rvalid)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter.
// Directed stimulus pushes expectations; one monitor compares.
module tb_memory_arbiter;

    localparam int RD_LAT = 2;
    localparam int STARVE = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_flag;
    logic        ntsc_frame_done;
    logic        vga_flag;
    logic [16:0] vga_addr;
    logic        vga_grant;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        ntsc_flag;
    logic [16:0] ntsc_addr;
    logic [35:0] ntsc_data;
    logic        ntsc_ack;
    logic        proc_req;
    logic        proc_we;
    logic [16:0] proc_addr;
    logic [35:0] proc_wdata;
    logic        proc_ack;
    logic [35:0] proc_rdata;
    logic        proc_rvalid;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_wdata;
    logic [35:0] mem_rdata;
    logic        display_buf;

    memory_arbiter #(
        .RD_LAT(RD_LAT),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clock(clock), .reset(reset),
        .frame_flag(frame_flag), .ntsc_frame_done(ntsc_frame_done),
        .vga_flag(vga_flag), .vga_addr(vga_addr), .vga_grant(vga_grant),
        .vga_pixel(vga_pixel), .done_vga(done_vga),
        .ntsc_flag(ntsc_flag), .ntsc_addr(ntsc_addr),
        .ntsc_data(ntsc_data), .ntsc_ack(ntsc_ack),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_ack(proc_ack),
        .proc_rdata(proc_rdata), .proc_rvalid(proc_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .display_buf(display_buf)
    );

    always #5 clock = ~clock;

    typedef struct { int due; logic [2:0] g; } gnt_t;
    typedef struct { int due; logic [17:0] a; logic we; logic [35:0] d; } mem_t;
    typedef struct { int due; logic [35:0] d; } rd_t;
    typedef struct { int due; logic b; } db_t;

    gnt_t gq [$];
    mem_t mq [$];
    rd_t  vq [$];
    rd_t  pq [$];
    db_t  dq [$];
    int   rq [$];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic exp_buf = 1'b0;
    logic end_req = 1'b0;

    function automatic logic [35:0] pat(input logic [17:0] a);
        return {a, ~a};
    endfunction

    // ZBT model: data for an address appears RD_LAT cycles later.
    logic [17:0] ap [RD_LAT];
    always @(posedge clock) begin
        ap[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
    end
    assign mem_rdata = pat(ap[RD_LAT-1]);

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(
        input logic v, n, p,
        input logic [16:0] va, na, pa,
        input logic [35:0] nd, pd,
        input logic pwe,
        input logic [2:0] eg
    );
        logic [17:0] ma;
        vga_flag = v; ntsc_flag = n; proc_req = p;
        vga_addr = va; ntsc_addr = na; proc_addr = pa;
        ntsc_data = nd; proc_wdata = pd; proc_we = pwe;
        gq.push_back('{cyc, eg});
        case (eg)
            3'b100: begin
                ma = {exp_buf, va};
                mq.push_back('{cyc + 1, ma, 1'b0, 36'h0});
                vq.push_back('{cyc + 2 + RD_LAT, pat(ma)});
            end
            3'b010: begin
                ma = {~exp_buf, na};
                mq.push_back('{cyc + 1, ma, 1'b1, nd});
            end
            3'b001: begin
                ma = {~exp_buf, pa};
                mq.push_back('{cyc + 1, ma, pwe, pd});
                if (!pwe) pq.push_back('{cyc + 2 + RD_LAT, pat(ma)});
            end
            default: ;
        endcase
        tick();
        vga_flag = 0; ntsc_flag = 0; proc_req = 0; proc_we = 0;
        frame_flag = 0; ntsc_frame_done = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    gnt_t g;
    mem_t m;
    rd_t  r;
    db_t  d;
    logic [35:0] last_vga = 0;
    logic [35:0] last_proc = 0;

    // Single checker: all comparisons happen here at the falling edge.
    always @(negedge clock) begin
        if (gq.size() != 0 && gq[0].due == cyc) begin
            g = gq.pop_front();
            chk("grants", {vga_grant, ntsc_ack, proc_ack}, g.g);
        end
        if (mq.size() != 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            chk("mem_addr", mem_addr, m.a);
            chk("mem_we", mem_we, m.we);
            if (m.we) chk("mem_wdata", mem_wdata, m.d);
        end else if (mem_we === 1'b1) begin
            chk("unexpected_mem_we", mem_we, 0);
        end
        if (vq.size() != 0 && vq[0].due < cyc) begin
            r = vq.pop_front();
            chk("missing_done_vga", 0, 1);
        end
        if (done_vga === 1'b1) begin
            if (vq.size() == 0) begin
                chk("unexpected_done_vga", done_vga, 0);
            end else begin
                r = vq.pop_front();
                chk("vga_cycle", cyc, r.due);
                chk("vga_pixel", vga_pixel, r.d);
                last_vga = r.d;
            end
        end else if (!reset) begin
            chk("vga_hold", vga_pixel, last_vga);
        end
        if (pq.size() != 0 && pq[0].due < cyc) begin
            r = pq.pop_front();
            chk("missing_proc_rvalid", 0, 1);
        end
        if (proc_rvalid === 1'b1) begin
            if (pq.size() == 0) begin
                chk("unexpected_proc_rvalid", proc_rvalid, 0);
            end else begin
                r = pq.pop_front();
                chk("proc_cycle", cyc, r.due);
                chk("proc_rdata", proc_rdata, r.d);
                last_proc = r.d;
            end
        end else if (!reset) begin
            chk("proc_hold", proc_rdata, last_proc);
        end
        if (dq.size() != 0 && dq[0].due == cyc) begin
            d = dq.pop_front();
            chk("display_buf", display_buf, d.b);
        end
        if (rq.size() != 0 && rq[0] == cyc) begin
            void'(rq.pop_front());
            chk("rst_ctl", {vga_grant, ntsc_ack, proc_ack, done_vga,
                proc_rvalid, mem_we, display_buf}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_vga_pixel", vga_pixel, 0);
            chk("rst_proc_rdata", proc_rdata, 0);
        end
        if (reset) begin
            last_vga = 0;
            last_proc = 0;
        end
        if (end_req) begin
            chk("vq_empty", vq.size(), 0);
            chk("pq_empty", pq.size(), 0);
            chk("mq_empty", mq.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: run did not end");
        $fatal(1);
    end

    initial begin
        reset = 1; vga_flag = 1; ntsc_flag = 0; proc_req = 0;
        proc_we = 0; frame_flag = 0; ntsc_frame_done = 0;
        vga_addr = 0; ntsc_addr = 0; proc_addr = 0;
        ntsc_data = 0; proc_wdata = 0;
        tick();
        gq.push_back('{cyc, 3'b000});
        rq.push_back(cyc);
        tick();
        tick();
        reset = 0; vga_flag = 0;

        // Single VGA read, offset 0x10
        issue(1, 0, 0, 17'h00010, 0, 0, 0, 0, 0, 3'b100);
        idle(6);

        // NTSC write at top offset lands in back buffer
        issue(0, 1, 0, 0, 17'h1FFFF, 0, 36'h123456789, 0, 0, 3'b010);
        idle(1);

        // Back-to-back mixed reads and a proc write
        issue(1, 0, 0, 17'h00100, 0, 0, 0, 0, 0, 3'b100);
        issue(0, 0, 1, 0, 0, 17'h00200, 0, 0, 0, 3'b001);
        issue(1, 0, 0, 17'h00300, 0, 0, 0, 0, 0, 3'b100);
        issue(0, 0, 1, 0, 0, 17'h00201, 0, 36'h0DEADBEEF, 1, 3'b001);
        issue(1, 1, 1, 17'h00070, 17'h71, 17'h72, 36'h71, 0, 0, 3'b100);
        issue(0, 1, 1, 0, 17'h71, 17'h72, 36'h71, 0, 0, 3'b010);
        idle(6);

        // Starvation: vga dominates, then proc promoted every 9th
        for (int i = 0; i < 12; i++)
            issue(1, 1, 1, 17'h40, 17'h60, 17'h50, 36'hABC, 0, 0, 3'b100);
        issue(0, 1, 1, 17'h40, 17'h60, 17'h50, 36'hABC, 0, 0, 3'b001);
        for (int i = 0; i < 8; i++)
            issue(0, 1, 1, 17'h40, 17'h60, 17'h50, 36'hABC, 0, 0, 3'b010);
        issue(0, 1, 1, 17'h40, 17'h60, 17'h50, 36'hABC, 0, 0, 3'b001);
        idle(6);

        // Frame done, later frame boundary swaps with reads in flight
        ntsc_frame_done = 1;
        idle(1);
        idle(3);
        issue(1, 0, 0, 17'h00007, 0, 0, 0, 0, 0, 3'b100);
        frame_flag = 1;
        dq.push_back('{cyc + 1, 1'b1});
        issue(1, 0, 0, 17'h00009, 0, 0, 0, 0, 0, 3'b100);
        exp_buf = 1;
        issue(1, 0, 0, 17'h00005, 0, 0, 0, 0, 0, 3'b100);
        issue(0, 1, 0, 0, 17'h00011, 0, 36'h55, 0, 0, 3'b010);
        idle(6);

        // Same-cycle done and boundary swaps at once
        ntsc_frame_done = 1; frame_flag = 1;
        dq.push_back('{cyc + 1, 1'b0});
        idle(1);
        exp_buf = 0;
        idle(1);
        // Lone boundary pulse does nothing
        frame_flag = 1;
        dq.push_back('{cyc + 1, 1'b0});
        dq.push_back('{cyc + 2, 1'b0});
        idle(3);

        // Swap to buffer 1, then reset kills an in-flight read
        ntsc_frame_done = 1; frame_flag = 1;
        dq.push_back('{cyc + 1, 1'b1});
        idle(1);
        exp_buf = 1;
        issue(1, 0, 0, 17'h00033, 0, 0, 0, 0, 0, 3'b100);
        void'(vq.pop_back());
        idle(1);
        reset = 1; vga_flag = 1;
        gq.push_back('{cyc, 3'b000});
        tick();
        rq.push_back(cyc);
        tick();
        reset = 0; vga_flag = 0;
        exp_buf = 0;
        dq.push_back('{cyc, 1'b0});
        idle(8);

        end_req = 1;
        repeat (5) @(posedge clock);
        $display("FAIL end_handshake: monitor did not finish");
        $fatal(1);
    end

endmodule
